// File: rtl/timex_link_pkg.sv
// Shared constants for the Timex link mailbox: status bit positions on both
// sides, the host control flush bit, and the FIFO pointer-width helper.
package timex_link_pkg;

    // Z80-side status byte: {h2z_ovr, z2h_ovr, z2h_full, fifo_full, count[3:0]}
    localparam int Z_STAT_H2Z_OVR   = 7;
    localparam int Z_STAT_Z2H_OVR   = 6;
    localparam int Z_STAT_Z2H_FULL  = 5;
    localparam int Z_STAT_FIFO_FULL = 4;

    // Host-side status byte: {z2h_ovr, 4'b0, h2z_ovr, fifo_full, z2h_full}
    localparam int H_STAT_Z2H_OVR   = 7;
    localparam int H_STAT_H2Z_OVR   = 2;
    localparam int H_STAT_FIFO_FULL = 1;
    localparam int H_STAT_Z2H_FULL  = 0;

    localparam int CTRL_FLUSH = 0;

    typedef struct packed {
        logic       sel;
        logic [7:0] data;
    } wr_cap_t;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/link_strobe_sync.sv
// Resynchronises one asynchronous active-low strobe to clk_16mhz and emits
// single-cycle fall/rise pulses on the synchronised level.
module link_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_16mhz,
    input  logic nRESET,
    input  logic pin,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    logic                   armed_q;

    // vld_q tracks when sync_q holds real pin samples rather than reset ones;
    // edges are only reported once the strobe has been seen high after reset,
    // so a strobe held low across reset release produces neither pulse.
    always_ff @(posedge clk_16mhz or negedge nRESET) begin
        if (!nRESET) begin
            sync_q  <= '1;
            vld_q   <= '0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1]);
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = armed_q &  prev_q & ~level;
    assign rise  = armed_q & ~prev_q &  level;

endmodule

// File: rtl/timex_link_mailbox.sv
// Byte mailbox between the Timex host connector and the FDD Z80 port 0x20:
// host->Z80 FIFO, Z80->host holding register, status bytes and overrun flags.
module timex_link_mailbox
    import timex_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_16mhz,
    input  logic       nRESET,
    input  logic [7:0] ext_din,
    output logic [7:0] ext_dout,
    output logic       ext_doe,
    input  logic       nEXT_RD,
    input  logic       nEXT_WR,
    input  logic       ext_sel_stat,
    input  logic [7:0] z80_din,
    output logic [7:0] z80_dout,
    output logic       z80_doe,
    input  logic       nTIIN,
    input  logic       nTIOUT,
    input  logic       z80_sel_stat,
    output logic       h2z_avail,
    output logic       z2h_full
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Strobe index: 0 host write, 1 host read, 2 Z80 write, 3 Z80 read
    logic [3:0] pins;
    logic [3:0] lvl_unused;
    logic [3:0] fall;
    logic [3:0] rise;

    assign pins = {nTIIN, nTIOUT, nEXT_RD, nEXT_WR};

    link_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [3:0] (
        .clk_16mhz (clk_16mhz),
        .nRESET    (nRESET),
        .pin       (pins),
        .level     (lvl_unused),
        .fall      (fall),
        .rise      (rise)
    );

    wr_cap_t h_cap;
    wr_cap_t z_cap;
    logic    h_rd_sel;
    logic    z_rd_sel;

    always_ff @(posedge clk_16mhz or negedge nRESET) begin
        if (!nRESET) begin
            h_cap    <= '0;
            z_cap    <= '0;
            h_rd_sel <= 1'b0;
            z_rd_sel <= 1'b0;
        end else begin
            if (fall[0]) h_cap    <= '{sel: ext_sel_stat, data: ext_din};
            if (fall[1]) h_rd_sel <= ext_sel_stat;
            if (fall[2]) z_cap    <= '{sel: z80_sel_stat, data: z80_din};
            if (fall[3]) z_rd_sel <= z80_sel_stat;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    hold;
    logic          h2z_ovr;
    logic          z2h_ovr;

    logic fifo_full;
    logic fifo_empty;
    logic host_wr_data;
    logic flush;
    logic push;
    logic pop;
    logic z_stat_clr;
    logic z_wr_data;
    logic host_rd_data;
    logic hold_load;

    assign fifo_full    = (count == DEPTH_C);
    assign fifo_empty   = (count == '0);

    assign host_wr_data = rise[0] & ~h_cap.sel;
    assign flush        = rise[0] &  h_cap.sel & h_cap.data[CTRL_FLUSH];
    assign push         = host_wr_data & ~fifo_full & ~flush;
    assign pop          = rise[3] & ~z_rd_sel & ~fifo_empty & ~flush;
    assign z_stat_clr   = rise[3] &  z_rd_sel;
    assign z_wr_data    = rise[2] & ~z_cap.sel;
    assign host_rd_data = rise[1] & ~h_rd_sel;
    // A host read retiring in the same cycle frees the register for the new byte
    assign hold_load    = z_wr_data & (~z2h_full | host_rd_data) & ~flush;

    always_ff @(posedge clk_16mhz) begin
        if (push) mem[wr_ptr] <= h_cap.data;
    end

    always_ff @(posedge clk_16mhz or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Overrun set takes priority over the Z80 status-read clear
    always_ff @(posedge clk_16mhz or negedge nRESET) begin
        if (!nRESET) begin
            hold     <= 8'h00;
            z2h_full <= 1'b0;
            h2z_ovr  <= 1'b0;
            z2h_ovr  <= 1'b0;
        end else begin
            if (host_wr_data && fifo_full) h2z_ovr <= 1'b1;
            else if (z_stat_clr)           h2z_ovr <= 1'b0;

            if (z_wr_data && z2h_full && !host_rd_data && !flush) z2h_ovr <= 1'b1;
            else if (z_stat_clr)                                  z2h_ovr <= 1'b0;

            if (flush) begin
                hold     <= 8'h00;
                z2h_full <= 1'b0;
            end else if (hold_load) begin
                hold     <= z_cap.data;
                z2h_full <= 1'b1;
            end else if (host_rd_data) begin
                z2h_full <= 1'b0;
            end
        end
    end

    logic [7:0] z_stat;
    logic [7:0] h_stat;

    always_comb begin
        z_stat                   = '0;
        z_stat[3:0]              = 4'(count);
        z_stat[Z_STAT_FIFO_FULL] = fifo_full;
        z_stat[Z_STAT_Z2H_FULL]  = z2h_full;
        z_stat[Z_STAT_Z2H_OVR]   = z2h_ovr;
        z_stat[Z_STAT_H2Z_OVR]   = h2z_ovr;

        h_stat                   = '0;
        h_stat[H_STAT_Z2H_FULL]  = z2h_full;
        h_stat[H_STAT_FIFO_FULL] = fifo_full;
        h_stat[H_STAT_H2Z_OVR]   = h2z_ovr;
        h_stat[H_STAT_Z2H_OVR]   = z2h_ovr;
    end

    assign z80_dout  = z80_sel_stat ? z_stat : (fifo_empty ? 8'hFF : mem[rd_ptr]);
    assign ext_dout  = ext_sel_stat ? h_stat : hold;
    assign z80_doe   = ~nTIIN;
    assign ext_doe   = ~nEXT_RD;
    assign h2z_avail = ~fifo_empty;

endmodule

// File: tb/tb_timex_link_mailbox.sv
// Randomised and directed bench for timex_link_mailbox against a queue-based
// model of the mailbox rules.
`timescale 1ns/1ps
module tb_timex_link_mailbox;

    localparam int DEPTH = 4;

    logic       clk_16mhz = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] ext_din = 8'h00;
    logic [7:0] ext_dout;
    logic       ext_doe;
    logic       nEXT_RD = 1'b1;
    logic       nEXT_WR = 1'b1;
    logic       ext_sel_stat = 1'b0;
    logic [7:0] z80_din = 8'h00;
    logic [7:0] z80_dout;
    logic       z80_doe;
    logic       nTIIN = 1'b1;
    logic       nTIOUT = 1'b1;
    logic       z80_sel_stat = 1'b0;
    logic       h2z_avail;
    logic       z2h_full;

    int checks = 0;
    int errors = 0;

    timex_link_mailbox #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_16mhz(clk_16mhz), .nRESET(nRESET),
        .ext_din(ext_din), .ext_dout(ext_dout), .ext_doe(ext_doe),
        .nEXT_RD(nEXT_RD), .nEXT_WR(nEXT_WR), .ext_sel_stat(ext_sel_stat),
        .z80_din(z80_din), .z80_dout(z80_dout), .z80_doe(z80_doe),
        .nTIIN(nTIIN), .nTIOUT(nTIOUT), .z80_sel_stat(z80_sel_stat),
        .h2z_avail(h2z_avail), .z2h_full(z2h_full)
    );

    always #31 clk_16mhz = ~clk_16mhz;

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    logic       m_hovr, m_zovr, m_zfull;
    logic [7:0] m_hold;

    function automatic void m_reset();
        mq.delete(); m_hovr = 0; m_zovr = 0; m_zfull = 0; m_hold = 8'h00;
    endfunction

    function automatic logic [7:0] m_z_stat();
        logic [3:0] n = 4'(mq.size());
        return {m_hovr, m_zovr, m_zfull, (mq.size() == DEPTH), n};
    endfunction

    function automatic logic [7:0] m_h_stat();
        return {m_zovr, 4'b0000, m_hovr, (mq.size() == DEPTH), m_zfull};
    endfunction

    function automatic logic [7:0] m_z_data();
        return (mq.size() == 0) ? 8'hFF : mq[0];
    endfunction

    function automatic void m_host_write(input logic sel, input logic [7:0] d);
        if (!sel) begin
            if (mq.size() < DEPTH) mq.push_back(d); else m_hovr = 1;
        end else if (d[0]) begin
            mq.delete(); m_hold = 8'h00; m_zfull = 0;
        end
    endfunction

    function automatic void m_z_write(input logic [7:0] d);
        if (!m_zfull) begin m_hold = d; m_zfull = 1; end else m_zovr = 1;
    endfunction

    // ---------------- bus cycles ----------------
    task automatic host_cyc(input bit rd, input logic sel, input logic [7:0] d,
                            output logic [7:0] q);
        @(negedge clk_16mhz);
        ext_sel_stat = sel; ext_din = d;
        if (rd) nEXT_RD = 1'b0; else nEXT_WR = 1'b0;
        repeat (6) @(negedge clk_16mhz);
        q = ext_dout;
        nEXT_RD = 1'b1; nEXT_WR = 1'b1;
        repeat (6) @(negedge clk_16mhz);
    endtask

    task automatic z_cyc(input bit rd, input logic sel, input logic [7:0] d,
                         output logic [7:0] q);
        @(negedge clk_16mhz);
        z80_sel_stat = sel; z80_din = d;
        if (rd) nTIIN = 1'b0; else nTIOUT = 1'b0;
        repeat (6) @(negedge clk_16mhz);
        q = z80_dout;
        nTIIN = 1'b1; nTIOUT = 1'b1;
        repeat (6) @(negedge clk_16mhz);
    endtask

    task automatic do_reset();
        @(negedge clk_16mhz);
        nRESET = 1'b0;
        repeat (3) @(negedge clk_16mhz);
        nRESET = 1'b1;
        repeat (5) @(negedge clk_16mhz);
        m_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] q;
        @(negedge clk_16mhz);
        nRESET = 1'b0; z80_sel_stat = 1'b0; ext_sel_stat = 1'b0;
        #5;
        checks++;
        if ({h2z_avail, z2h_full, ext_doe, z80_doe} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b want=0000", {h2z_avail, z2h_full, ext_doe, z80_doe});
        end
        checks++;
        if (z80_dout !== 8'hFF || ext_dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout got z80=%h ext=%h want FF/00", z80_dout, ext_dout);
        end
        repeat (2) @(negedge clk_16mhz);
        nRESET = 1'b1;
        repeat (5) @(negedge clk_16mhz);
        m_reset();
        z_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_zstat got=%h want=00", q); end
        z_cyc(1, 0, 8'h00, q);
        checks++;
        if (q !== 8'hFF) begin errors++; $display("FAIL reset_zdata got=%h want=FF", q); end
    endtask

    task automatic test_overrun();
        logic [7:0] q, exp;
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (bytes[i]) begin host_cyc(0, 0, bytes[i], q); m_host_write(0, bytes[i]); end
        z_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== 8'h94 || q !== m_z_stat()) begin
            errors++; $display("FAIL ovr_stat got=%h want=94", q);
        end
        m_hovr = 0;
        m_hovr = 1; // status read above: model clears after compare
        m_hovr = 0;
        m_zovr = 0;
        for (int i = 0; i < 4; i++) begin
            z_cyc(1, 0, 8'h00, q);
            checks++;
            exp = 8'h11 * 8'(i + 1);
            if (q !== exp) begin errors++; $display("FAIL ovr_pop%0d got=%h want=%h", i, q, exp); end
            void'(mq.pop_front());
        end
        z_cyc(1, 0, 8'h00, q);
        checks++;
        if (q !== 8'hFF) begin errors++; $display("FAIL ovr_empty got=%h want=FF", q); end
        z_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL ovr_cleared got=%h want=00", q); end
    endtask

    task automatic test_z2h();
        logic [7:0] q;
        z_cyc(0, 0, 8'hA5, q); m_z_write(8'hA5);
        z_cyc(0, 0, 8'h5A, q); m_z_write(8'h5A);
        host_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== 8'h81 || q !== m_h_stat()) begin errors++; $display("FAIL z2h_hstat got=%h want=81", q); end
        host_cyc(1, 0, 8'h00, q);
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL z2h_data got=%h want=A5", q); end
        m_zfull = 0;
        checks++;
        if (z2h_full !== 1'b0) begin errors++; $display("FAIL z2h_full_clr got=%b want=0", z2h_full); end
        host_cyc(1, 0, 8'h00, q);
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL z2h_reread got=%h want=A5", q); end
        z_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== m_z_stat()) begin errors++; $display("FAIL z2h_zstat got=%h want=%h", q, m_z_stat()); end
        m_hovr = 0; m_zovr = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, d, exp;
        for (int i = 0; i < 2; i++) begin d = 8'($urandom); host_cyc(0, 0, d, q); m_host_write(0, d); end
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            exp = m_z_data();
            @(negedge clk_16mhz);
            ext_sel_stat = 0; ext_din = d; z80_sel_stat = 0;
            nEXT_WR = 1'b0; nTIIN = 1'b0;
            repeat (6) @(negedge clk_16mhz);
            q = z80_dout;
            nEXT_WR = 1'b1; nTIIN = 1'b1;
            repeat (6) @(negedge clk_16mhz);
            checks++;
            if (q !== exp) begin errors++; $display("FAIL b2b_data%0d got=%h want=%h", i, q, exp); end
            void'(mq.pop_front());
            mq.push_back(d);
        end
        z_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== 8'h02) begin errors++; $display("FAIL b2b_count got=%h want=02", q); end
        for (int i = 0; i < 2; i++) begin
            z_cyc(1, 0, 8'h00, q);
            checks++;
            if (q !== mq[0]) begin errors++; $display("FAIL b2b_drain%0d got=%h want=%h", i, q, mq[0]); end
            void'(mq.pop_front());
        end
    endtask

    task automatic test_flush();
        logic [7:0] q, exp;
        for (int i = 0; i < 3; i++) begin host_cyc(0, 0, 8'(8'h60 + i), q); m_host_write(0, 8'(8'h60 + i)); end
        z_cyc(0, 0, 8'hC3, q); m_z_write(8'hC3);
        z_cyc(0, 0, 8'h3C, q); m_z_write(8'h3C);
        host_cyc(0, 1, 8'h01, q); m_host_write(1, 8'h01);
        checks++;
        if ({h2z_avail, z2h_full} !== 2'b00) begin
            errors++; $display("FAIL flush_flags got=%b want=00", {h2z_avail, z2h_full});
        end
        exp = m_z_stat();
        z_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== 8'h40 || q !== exp) begin errors++; $display("FAIL flush_stat got=%h want=40", q); end
        m_hovr = 0; m_zovr = 0;
        host_cyc(1, 0, 8'h00, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL flush_hold got=%h want=00", q); end
    endtask

    task automatic test_reset_midstrobe();
        logic [7:0] q;
        @(negedge clk_16mhz);
        ext_sel_stat = 0; ext_din = 8'h77; nEXT_WR = 1'b0;
        repeat (5) @(negedge clk_16mhz);
        nRESET = 1'b0;
        repeat (3) @(negedge clk_16mhz);
        nRESET = 1'b1;
        repeat (8) @(negedge clk_16mhz);
        nEXT_WR = 1'b1;
        repeat (8) @(negedge clk_16mhz);
        m_reset();
        checks++;
        if (h2z_avail !== 1'b0) begin errors++; $display("FAIL midrst_avail got=%b want=0", h2z_avail); end
        z_cyc(1, 1, 8'h00, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL midrst_stat got=%h want=00", q); end
    endtask

    task automatic test_random();
        logic [7:0] q, d, exp;
        int op;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            case (op)
                0, 1, 2: begin host_cyc(0, 0, d, q); m_host_write(0, d); end
                3, 4: begin
                    exp = m_z_data(); z_cyc(1, 0, 8'h00, q);
                    checks++;
                    if (q !== exp) begin errors++; $display("FAIL rnd_zdata n=%0d got=%h want=%h", n, q, exp); end
                    if (mq.size() > 0) void'(mq.pop_front());
                end
                5: begin
                    exp = m_z_stat(); z_cyc(1, 1, 8'h00, q);
                    checks++;
                    if (q !== exp) begin errors++; $display("FAIL rnd_zstat n=%0d got=%h want=%h", n, q, exp); end
                    m_hovr = 0; m_zovr = 0;
                end
                6: begin z_cyc(0, 0, d, q); m_z_write(d); end
                7: begin
                    exp = m_hold; host_cyc(1, 0, 8'h00, q);
                    checks++;
                    if (q !== exp) begin errors++; $display("FAIL rnd_hdata n=%0d got=%h want=%h", n, q, exp); end
                    m_zfull = 0;
                end
                8: begin
                    exp = m_h_stat(); host_cyc(1, 1, 8'h00, q);
                    checks++;
                    if (q !== exp) begin errors++; $display("FAIL rnd_hstat n=%0d got=%h want=%h", n, q, exp); end
                end
                default: begin
                    d[0] = ($urandom_range(0, 2) == 0);
                    host_cyc(0, 1, d, q); m_host_write(1, d);
                end
            endcase
            checks++;
            if ({h2z_avail, z2h_full} !== {mq.size() != 0, m_zfull}) begin
                errors++;
                $display("FAIL rnd_flags n=%0d got=%b want=%b", n, {h2z_avail, z2h_full}, {mq.size() != 0, m_zfull});
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_overrun();
        test_z2h();
        do_reset();
        test_back_to_back();
        do_reset();
        test_flush();
        test_reset_midstrobe();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
